// File: rtl/tdoa_pkg.sv
// Shared types and constants for the TDOA capture/framing engine.
package tdoa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_SEND,
    ST_HOLDOFF
  } state_t;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  // Header, sequence, mask, N_CH timestamps, checksum.
  function automatic int unsigned frame_len(input int unsigned n_ch, input int unsigned ts_w);
    return 4 + n_ch * (ts_w / 8);
  endfunction

endpackage

// File: rtl/trigger_sync.sv
// Two-flop synchronizer followed by a rising-edge detector (one-cycle pulse).
module trigger_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic [2:0] sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sh <= '0;
    else       sh <= {sh[1:0], d};
  end

  assign pulse = sh[1] & ~sh[2];

endmodule

// File: rtl/tdoa_capture_packetizer.sv
// N-channel first-edge timestamp capture with checksummed byte-frame output
// over a valid/ready interface.
module tdoa_capture_packetizer
  import tdoa_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned TS_W    = 32,
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned HOLDOFF = 1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] trigg,
  input  logic [N_CH-1:0] ch_enable,
  input  logic            arm,
  output logic [7:0]      tx_byte,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            busy,
  output logic [7:0]      frame_seq
);

  localparam int unsigned NB   = TS_W / 8;
  localparam int unsigned FLEN = frame_len(N_CH, TS_W);
  localparam int unsigned IW   = $clog2(FLEN);
  localparam int unsigned HW   = $clog2(HOLDOFF + 1);
  localparam logic [TS_W-1:0] TS_LAST = TS_W'(TIMEOUT - 1);

  if (N_CH < 1 || N_CH > 8 || TS_W < 8 || TS_W > 32 || (TS_W % 8) != 0 ||
      TIMEOUT < 2 || 64'(TIMEOUT) > ((64'd1 << TS_W) - 64'd1) || HOLDOFF < 1) begin : g_param_check
    $error("tdoa_capture_packetizer: parameter out of range");
  end

  state_t            state, state_nxt;
  logic [N_CH-1:0]   edge_p, hit, en_q, captured;
  logic [TS_W-1:0]   ts_q [N_CH];
  logic [TS_W-1:0]   counter;
  logic [HW-1:0]     hold_cnt;
  logic [IW-1:0]     idx;
  logic [7:0]        csum, byte_mux;
  logic              xfer, last_byte;

  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    trigger_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (trigg[g]),
      .pulse (edge_p[g])
    );
  end

  assign hit = edge_p & en_q & ~captured;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    xfer      = (state == ST_SEND) && tx_ready;
    last_byte = (idx == IW'(FLEN - 1));
    tx_valid  = (state == ST_SEND);
    tx_byte   = (state == ST_SEND) ? byte_mux : 8'h00;
    case (state)
      ST_IDLE:    if (arm) state_nxt = ST_ARMED;
      // All enabled channels edging together closes the event without a CAPTURE cycle.
      ST_ARMED:   if (!arm || en_q == '0) state_nxt = ST_IDLE;
                  else if (hit != '0)     state_nxt = (hit == en_q) ? ST_SEND : ST_CAPTURE;
      ST_CAPTURE: if ((captured | hit) == en_q || counter == TS_LAST) state_nxt = ST_SEND;
      ST_SEND:    if (xfer && last_byte) state_nxt = ST_HOLDOFF;
      ST_HOLDOFF: if (hold_cnt == HW'(HOLDOFF - 1)) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Checksum byte is the running XOR, so it is the fall-through case.
  always_comb begin
    byte_mux = csum;
    if (idx == IW'(0))      byte_mux = FRAME_HDR;
    else if (idx == IW'(1)) byte_mux = frame_seq;
    else if (idx == IW'(2)) byte_mux = 8'(captured);
    else begin
      for (int unsigned c = 0; c < N_CH; c++)
        for (int unsigned b = 0; b < NB; b++)
          if (idx == IW'(3 + c * NB + b)) byte_mux = ts_q[c][TS_W-1-8*b -: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q      <= '0;
      captured  <= '0;
      counter   <= '0;
      hold_cnt  <= '0;
      idx       <= '0;
      csum      <= '0;
      busy      <= 1'b0;
      frame_seq <= '0;
      for (int unsigned c = 0; c < N_CH; c++) ts_q[c] <= '1;
    end else begin
      busy <= (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          idx  <= '0;
          csum <= '0;
          if (arm) begin
            en_q     <= ch_enable;
            captured <= '0;
            for (int unsigned c = 0; c < N_CH; c++) ts_q[c] <= '1;
          end
        end
        ST_ARMED: if (state_nxt == ST_CAPTURE || state_nxt == ST_SEND) begin
          counter  <= TS_W'(1);
          captured <= hit;
          for (int unsigned c = 0; c < N_CH; c++) if (hit[c]) ts_q[c] <= '0;
        end
        ST_CAPTURE: begin
          counter  <= counter + TS_W'(1);
          captured <= captured | hit;
          for (int unsigned c = 0; c < N_CH; c++) if (hit[c]) ts_q[c] <= counter;
        end
        ST_SEND: if (xfer) begin
          csum <= csum ^ tx_byte;
          idx  <= idx + IW'(1);
          if (last_byte) begin
            frame_seq <= frame_seq + 8'd1;
            hold_cnt  <= '0;
          end
        end
        ST_HOLDOFF: hold_cnt <= hold_cnt + HW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tdoa_capture_packetizer.sv
// Randomized/directed bench for tdoa_capture_packetizer with a frame-level
// reference model built from pin edge times.
module tb_tdoa_capture_packetizer;

  localparam int N_CH    = 4;
  localparam int TS_W    = 32;
  localparam int TIMEOUT = 1000;
  localparam int HOLDOFF = 20;
  localparam int NB      = TS_W / 8;
  localparam int FLEN    = 4 + N_CH * NB;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] trigg, ch_enable;
  logic            arm, tx_ready, tx_valid, busy;
  logic [7:0]      tx_byte, frame_seq;

  int checks   = 0;
  int failures = 0;
  int seq_exp  = 0;
  int off_v [N_CH];
  logic [7:0] exp_bytes [FLEN];
  int exp_lat, exp_base;

  always #5 clk = ~clk;

  tdoa_capture_packetizer #(
    .N_CH    (N_CH),
    .TS_W    (TS_W),
    .TIMEOUT (TIMEOUT),
    .HOLDOFF (HOLDOFF)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .trigg     (trigg),
    .ch_enable (ch_enable),
    .arm       (arm),
    .tx_byte   (tx_byte),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .frame_seq (frame_seq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Timestamps are pin-edge offsets from the earliest enabled edge; an edge
  // TIMEOUT or more cycles after it misses the window.
  task automatic build_expect(input logic [N_CH-1:0] en, input int seq);
    logic [N_CH-1:0] mask;
    logic [TS_W-1:0] ts [N_CH];
    int maxd;
    logic [7:0] x;
    mask = '0; exp_base = -1; maxd = 0;
    for (int c = 0; c < N_CH; c++)
      if (en[c] && off_v[c] >= 0 && (exp_base < 0 || off_v[c] < exp_base)) exp_base = off_v[c];
    for (int c = 0; c < N_CH; c++) begin
      ts[c] = '1;
      if (en[c] && off_v[c] >= 0 && (off_v[c] - exp_base) < TIMEOUT) begin
        mask[c] = 1'b1;
        ts[c]   = TS_W'(off_v[c] - exp_base);
        if (off_v[c] - exp_base > maxd) maxd = off_v[c] - exp_base;
      end
    end
    exp_lat = (mask == en) ? maxd + 1 : TIMEOUT;
    exp_bytes[0] = 8'hA5;
    exp_bytes[1] = 8'(seq);
    exp_bytes[2] = 8'(mask);
    for (int c = 0; c < N_CH; c++)
      for (int k = 0; k < NB; k++)
        exp_bytes[3 + c * NB + k] = 8'(ts[c] >> (8 * (NB - 1 - k)));
    x = '0;
    for (int i = 0; i < FLEN - 1; i++) x ^= exp_bytes[i];
    exp_bytes[FLEN-1] = x;
  endtask

  task automatic run_event(input logic [N_CH-1:0] en, input int ready_pct,
                           input int abort_after, input bit poke);
    int n, j, budget, vcount;
    bit seen, hold;
    logic [7:0] held;
    trigg = '0; arm = 1'b0; tx_ready = 1'b0;
    for (int k = 0; k < 300 && busy; k++) tick();
    check("idle_before_arm", busy, 0);
    check("seq_before_frame", frame_seq, seq_exp);
    tick(); tick();
    ch_enable = en; arm = 1'b1;
    tick(); tick(); tick();
    build_expect(en, seq_exp);
    n = 0; seen = 0; hold = 0; held = '0;
    budget = TIMEOUT + 200 + FLEN * 40;
    for (j = 0; j < budget; j++) begin
      if (tx_valid && !seen) begin
        seen = 1;
        check("valid_rise_cycle", j, exp_base + exp_lat + 2);
      end
      if (hold) begin
        check("hold_valid", tx_valid, 1);
        check("hold_byte", tx_byte, held);
      end
      for (int c = 0; c < N_CH; c++) if (off_v[c] == j) trigg[c] = 1'b1;
      tx_ready = ($urandom_range(99) < ready_pct);
      if (tx_valid && tx_ready) begin
        check($sformatf("byte%0d", n), tx_byte, exp_bytes[n]);
        n++;
      end
      hold = tx_valid && !tx_ready;
      held = tx_byte;
      tick();
      if (n == FLEN || (abort_after > 0 && n == abort_after)) break;
    end
    check("valid_rise_seen", seen, 1);
    check("bytes_transferred", n, (abort_after > 0) ? abort_after : FLEN);
    if (abort_after > 0) begin
      arm = 1'b0; rst = 1'b1;
      #1;
      check("abort_valid", tx_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_byte", tx_byte, 0);
      check("abort_seq", frame_seq, 0);
      tick();
      rst = 1'b0; tx_ready = 1'b0; trigg = '0;
      seq_exp = 0;
    end else begin
      check("valid_drop_after_cksum", tx_valid, 0);
      seq_exp = (seq_exp + 1) % 256;
      check("seq_after_frame", frame_seq, seq_exp);
      tx_ready = 1'b0;
      if (poke) begin
        trigg = '0; tick(); tick();
        trigg = '1; tick(); tick();
        trigg = '0;
        vcount = 0;
        for (int k = 0; k < HOLDOFF + 15; k++) begin
          tick();
          if (tx_valid) vcount++;
        end
        check("holdoff_edges_ignored", vcount, 0);
      end
    end
  endtask

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog observed=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    logic [N_CH-1:0] en_r;
    rst = 1'b1; trigg = '0; ch_enable = '0; arm = 1'b0; tx_ready = 1'b0;
    tick(); tick();
    check("reset_tx_byte", tx_byte, 0);
    check("reset_tx_valid", tx_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_seq", frame_seq, 0);
    rst = 1'b0;
    tick();

    off_v = '{0, 100, 250, 40};
    run_event(4'hF, 100, 0, 0);
    off_v = '{3, 20, -1, 7};
    run_event(4'hF, 100, 0, 0);
    off_v = '{0, 999, -1, 1000};
    run_event(4'hF, 100, 0, 0);
    off_v = '{5, 2, 5, -1};
    run_event(4'b0101, 100, 0, 0);
    off_v = '{0, 100, 250, 40};
    run_event(4'hF, 30, 0, 1);
    off_v = '{0, 100, 250, 40};
    run_event(4'hF, 100, 5, 0);

    trigg = '0; arm = 1'b0;
    for (int k = 0; k < 300 && busy; k++) tick();
    ch_enable = '0; arm = 1'b1; tx_ready = 1'b1;
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 5) trigg = '1;
      tick();
      if (tx_valid) vcount++;
    end
    check("no_enable_no_frame", vcount, 0);
    arm = 1'b0; trigg = '0; tx_ready = 1'b0;

    for (int i = 0; i < 257; i++) begin
      en_r = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      for (int c = 0; c < N_CH; c++) off_v[c] = int'($urandom_range(0, 40));
      run_event(en_r, (i % 8 == 3) ? 50 : 100, 0, (i % 16 == 0) || (i == 256));
    end
    check("seq_wrapped", frame_seq, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdoa_capture_packetizer.md
# tdoa_capture_packetizer

Parametrised N-channel trigger timestamp capture and framing engine. It succeeds the fixed four-counter, combiner and UART-buffer chain in the FPGA top level. It arms on command, timestamps the first rising edge on each enabled channel relative to the earliest one, and closes the event when all channels have fired or a timeout expires. It then streams a checksummed byte frame over a valid/ready interface to the UART transmitter adapter.

## Interface
- N_CH, 4, number of trigger channels (1..8)
- TS_W, 32, timestamp width in bits (multiple of 8, 8..32)
- TIMEOUT, 100000, capture window in clk cycles (2..2^TS_W-1, elaboration check)
- HOLDOFF, 1000, dead-time cycles after a frame before re-arming (≥1)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; all state cleared
- trigg  in  N_CH  raw asynchronous trigger inputs
- ch_enable  in  N_CH  channel enable, sampled when entering ARMED
- arm  in  1  level; engine leaves IDLE while high
- tx_byte  out  8  frame byte
- tx_valid  out  1  tx_byte valid
- tx_ready  in  1  downstream accepts byte
- busy  out  1  high in any state except IDLE
- frame_seq  out  8  sequence number of the next frame

## Operation
- Each trigg bit goes through a 2-flop synchronizer and a rising-edge detector, producing a one-cycle pulse.
- States: IDLE, ARMED, CAPTURE, SEND, HOLDOFF.
- IDLE → ARMED when arm=1. On entry, latch ch_enable into en_q. If en_q=0, return to IDLE.
- ARMED:
  - First cycle with any enabled edge: counter:=1, record timestamp 0 for every channel edging that cycle, go to CAPTURE.
  - arm=0 returns to IDLE.
- CAPTURE:
  - Counter increments every cycle.
  - An enabled, not-yet-captured channel with an edge stores the current counter value.
  - Later edges on an already-captured channel are ignored.
  - Go to SEND when captured==en_q, or when counter==TIMEOUT-1 (that cycle's edges are still captured).
- SEND: emit the frame in this byte order:
  - 0xA5
  - frame_seq
  - captured mask, zero-extended to 8 bits
  - per channel 0..N_CH-1: TS_W/8 bytes, MSB first; uncaptured or disabled channels send all-ones
  - checksum: XOR of all preceding bytes
- Frame length = 4 + N_CH·TS_W/8 bytes.
- After the checksum byte is accepted: frame_seq += 1 (wraps 255→0), go to HOLDOFF.
- HOLDOFF: count HOLDOFF cycles, then return to IDLE. Edges during SEND and HOLDOFF are discarded.
- Reset values: tx_byte=0x00, tx_valid=0, busy=0, frame_seq=0x00. All timestamps become all-ones, captured=0, state=IDLE.
- Reset mid-frame aborts the frame. No partial resume. Downstream sees tx_valid drop asynchronously.

## Timing
- Pin-to-capture latency is 3 cycles (2 sync + 1 edge), equal on all channels, so differences are exact to ±1 cycle of pin skew.
- Timestamp resolution is 1 clk.
- Simultaneous edges in the same cycle get identical timestamps.
- tx_valid rises in the first SEND cycle, one cycle after the closing CAPTURE cycle.
- Handshake:
  - A byte transfers on a cycle with tx_valid&tx_ready.
  - The next byte is presented the following cycle with tx_valid still high, so full rate is 1 byte/cycle.
  - While tx_ready=0, tx_byte and tx_valid are held stable.
  - tx_valid is never withdrawn before acceptance, except on reset.
- tx_valid deasserts in the cycle after the checksum byte transfers.
- busy is registered and follows the state with 1 cycle delay.

## Structure
- Package tdoa_pkg holds:
  - state enum
  - FRAME_HDR=8'hA5
  - function frame_len(N_CH,TS_W)
- Submodule trigger_sync (2-flop synchronizer + rising-edge pulse) is instantiated N_CH times via generate.
- The core holds the FSM, the capture registers (N_CH×TS_W), the byte index counter, the running checksum register, and the byte mux.

## Test plan
- Defaults, all enabled, arm=1, tx_ready=1:
  - Stimulus: edges ch0@t, ch3@t+40, ch1@t+100, ch2@t+250.
  - Response: 20-byte frame A5 00 0F, then timestamps 00000000, 00000064, 000000FA, 00000028, then the correct XOR checksum.
- Timeout:
  - Stimulus: ch2 never fires, TIMEOUT=1000.
  - Response: mask 0x0B, ch2 field FFFFFFFF, tx_valid rises exactly 1000 cycles after the first edge.
- Enable mask and simultaneity:
  - Stimulus: ch_enable=4'b0101; ch0 and ch2 edge in the same cycle; ch1 also toggles.
  - Response: SEND starts immediately, mask 0x05, both timestamps 0, ch1/ch3 fields all-ones.
- Backpressure:
  - Stimulus: tx_ready random 30% high.
  - Response: tx_byte stable whenever valid&!ready, byte sequence identical to the tx_ready=1 run, no bytes lost or duplicated.
- Reset mid-SEND:
  - Stimulus: assert reset after byte 5.
  - Response: tx_valid=0 and busy=0 immediately; next frame starts with A5 00.
- 257 consecutive events:
  - Response: frame_seq runs 00..FF then 00.
  - Edges injected during HOLDOFF produce no capture.
